// File: rtl/round_done_pkg.sv
// Shared types and defaults for the hardened round-done counter.
package round_done_pkg;

  localparam int unsigned CNT_W_DEF = 4;
  localparam int unsigned LD_M0_DEF = 11;
  localparam int unsigned LD_M1_DEF = 13;
  localparam int unsigned LD_M2_DEF = 15;

  typedef enum logic [1:0] {
    M128      = 2'd0,
    M192      = 2'd1,
    M256      = 2'd2,
    M_ILLEGAL = 2'd3
  } mode_t;

  // Default round count for a mode; the illegal mode maps to zero.
  function automatic logic [CNT_W_DEF-1:0] load_val(mode_t m);
    logic [CNT_W_DEF-1:0] v;
    case (m)
      M128:    v = CNT_W_DEF'(LD_M0_DEF);
      M192:    v = CNT_W_DEF'(LD_M1_DEF);
      M256:    v = CNT_W_DEF'(LD_M2_DEF);
      default: v = {CNT_W_DEF{1'b0}};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/round_done_hardened_cnt.sv
// One copy of the round counter. INV=0 holds the true count (decrement,
// saturate at 0); INV=1 holds its complement (increment, saturate at ones).
module rd_cnt_cell #(
  parameter int unsigned W   = 4,
  parameter bit          INV = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         en,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] RST_VAL = {W{INV}};
  localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear beats load beats a saturating step.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = RST_VAL;
    end else if (ld) begin
      cnt_d = INV ? ~ld_val : ld_val;
    end else if (en && (cnt_q != RST_VAL)) begin
      cnt_d = INV ? (cnt_q + ONE) : (cnt_q - ONE);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with its own reset encoding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/round_done_hardened.sv
// Round-done generator with a complemented shadow counter and sticky alarm.
module round_done_hardened
  import round_done_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned LD_M0 = LD_M0_DEF,
  parameter int unsigned LD_M1 = LD_M1_DEF,
  parameter int unsigned LD_M2 = LD_M2_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [1:0]       mode,
  input  logic             en,
  input  logic             abort,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] remain,
  output logic             alarm
);

  localparam logic [CNT_W-1:0] LD0 = CNT_W'(LD_M0);
  localparam logic [CNT_W-1:0] LD1 = CNT_W'(LD_M1);
  localparam logic [CNT_W-1:0] LD2 = CNT_W'(LD_M2);
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  mode_t            mode_s;
  logic [CNT_W-1:0] ld_val_s;
  logic [CNT_W-1:0] cnt_p_s;
  logic [CNT_W-1:0] cnt_s_s;
  logic             mismatch_s;
  logic             fault_s;
  logic             clr_s;
  logic             ld_ok_s;
  logic             ld_bad_s;
  logic             step_s;
  logic             done_q;
  logic             done_d;
  logic             alarm_q;
  logic             alarm_d;

  assign mode_s = mode_t'(mode);

  // Load value selected by mode; the illegal mode never reaches the counters.
  always_comb begin
    ld_val_s = {CNT_W{1'b0}};
    case (mode_s)
      M128:    ld_val_s = LD0;
      M192:    ld_val_s = LD1;
      M256:    ld_val_s = LD2;
      default: ld_val_s = {CNT_W{1'b0}};
    endcase
  end

  // Priority: alarm (or a live mismatch) > abort > ld > count.
  always_comb begin
    mismatch_s = (cnt_p_s != ~cnt_s_s);
    fault_s    = alarm_q | mismatch_s;
    clr_s      = fault_s | abort;
    ld_ok_s    = ld & (mode_s != M_ILLEGAL) & ~clr_s;
    ld_bad_s   = ld & (mode_s == M_ILLEGAL) & ~clr_s;
    step_s     = en & ~ld & ~clr_s;
    done_d     = (cnt_p_s == ONE) & en & ~ld & ~abort & ~fault_s;
    alarm_d    = alarm_q | mismatch_s | ld_bad_s;
  end

  rd_cnt_cell #(.W(CNT_W), .INV(1'b0)) u_cnt_p (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr_s),
    .ld     (ld_ok_s),
    .ld_val (ld_val_s),
    .en     (step_s),
    .cnt_o  (cnt_p_s)
  );

  rd_cnt_cell #(.W(CNT_W), .INV(1'b1)) u_cnt_s (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr_s),
    .ld     (ld_ok_s),
    .ld_val (ld_val_s),
    .en     (step_s),
    .cnt_o  (cnt_s_s)
  );

  // Completion pulse and sticky alarm registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      done_q  <= done_d;
      alarm_q <= alarm_d;
    end
  end

  assign done   = done_q;
  assign alarm  = alarm_q;
  assign busy   = (cnt_p_s != {CNT_W{1'b0}});
  assign remain = cnt_p_s;

endmodule

// File: tb/tb_round_done_hardened.sv
// Directed self-checking bench for round_done_hardened.
module tb_round_done_hardened;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       en = 1'b0;
  logic       abort = 1'b0;
  logic       done;
  logic       busy;
  logic [3:0] remain;
  logic       alarm;

  int n_checks = 0;
  int n_errors = 0;

  round_done_hardened dut (
    .clk    (clk),
    .rst    (rst),
    .ld     (ld),
    .mode   (mode),
    .en     (en),
    .abort  (abort),
    .done   (done),
    .busy   (busy),
    .remain (remain),
    .alarm  (alarm)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_rst;
    ld = 1'b0; abort = 1'b0; en = 1'b0; mode = 2'd0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++; if (remain !== 4'd0) begin n_errors++; $display("FAIL reset_remain got %0d exp 0", remain); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b exp 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (alarm !== 1'b0) begin n_errors++; $display("FAIL reset_alarm got %b exp 0", alarm); end
    rst = 1'b0;
  endtask

  task automatic test_mode0;
    logic [3:0] exp_rem;
    do_rst();
    ld = 1'b1; mode = 2'd0; en = 1'b1;
    tick();
    ld = 1'b0;
    n_checks++; if (remain !== 4'd11) begin n_errors++; $display("FAIL m0_load remain got %0d exp 11", remain); end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL m0_load busy got %b exp 1", busy); end
    for (int k = 1; k <= 11; k++) begin
      tick();
      exp_rem = 4'(11 - k);
      n_checks++; if (remain !== exp_rem) begin n_errors++; $display("FAIL m0_remain k=%0d got %0d exp %0d", k, remain, exp_rem); end
      n_checks++; if (done !== (k == 11)) begin n_errors++; $display("FAIL m0_done k=%0d got %b exp %b", k, done, (k == 11)); end
      n_checks++; if (busy !== (k < 11)) begin n_errors++; $display("FAIL m0_busy k=%0d got %b exp %b", k, busy, (k < 11)); end
    end
    tick();
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL m0_done_after got %b exp 0", done); end
  endtask

  task automatic test_stall;
    int act;
    logic [3:0] exp_rem;
    do_rst();
    ld = 1'b1; mode = 2'd2; en = 1'b1;
    tick();
    ld = 1'b0;
    act = 0;
    n_checks++; if (remain !== 4'd15) begin n_errors++; $display("FAIL m2_load remain got %0d exp 15", remain); end
    for (int n = 1; n <= 20; n++) begin
      en = !(n >= 6 && n <= 8);
      tick();
      if (en) act++;
      exp_rem = (act >= 15) ? 4'd0 : 4'(15 - act);
      n_checks++; if (remain !== exp_rem) begin n_errors++; $display("FAIL m2_remain n=%0d got %0d exp %0d", n, remain, exp_rem); end
      n_checks++; if (done !== (n == 18)) begin n_errors++; $display("FAIL m2_done n=%0d got %b exp %b", n, done, (n == 18)); end
    end
  endtask

  task automatic test_back_to_back;
    do_rst();
    ld = 1'b1; mode = 2'd0; en = 1'b1;
    tick();
    ld = 1'b0;
    repeat (10) tick();
    n_checks++; if (remain !== 4'd1) begin n_errors++; $display("FAIL reload_pre remain got %0d exp 1", remain); end
    ld = 1'b1; mode = 2'd1;
    tick();
    ld = 1'b0;
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reload_done got %b exp 0", done); end
    n_checks++; if (remain !== 4'd13) begin n_errors++; $display("FAIL reload_remain got %0d exp 13", remain); end
    for (int k = 1; k <= 14; k++) begin
      tick();
      n_checks++; if (done !== (k == 13)) begin n_errors++; $display("FAIL reload_done k=%0d got %b exp %b", k, done, (k == 13)); end
    end
  endtask

  task automatic test_abort;
    do_rst();
    ld = 1'b1; mode = 2'd0; en = 1'b1;
    tick();
    ld = 1'b0;
    repeat (6) tick();
    n_checks++; if (remain !== 4'd5) begin n_errors++; $display("FAIL abort_pre remain got %0d exp 5", remain); end
    abort = 1'b1; ld = 1'b1; mode = 2'd2;
    tick();
    abort = 1'b0; ld = 1'b0;
    n_checks++; if (remain !== 4'd0) begin n_errors++; $display("FAIL abort_remain got %0d exp 0", remain); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL abort_done got %b exp 0", done); end
    n_checks++; if (alarm !== 1'b0) begin n_errors++; $display("FAIL abort_alarm got %b exp 0", alarm); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL abort_idle_done k=%0d got %b exp 0", k, done); end
    end
  endtask

  task automatic test_fault;
    do_rst();
    ld = 1'b1; mode = 2'd0; en = 1'b1;
    tick();
    ld = 1'b0;
    repeat (5) tick();
    n_checks++; if (remain !== 4'd6) begin n_errors++; $display("FAIL fault_pre remain got %0d exp 6", remain); end
    // shadow of 6 is 4'b1001; flip bit 0
    force dut.u_cnt_s.cnt_q = 4'b1000;
    @(posedge clk);
    #1;
    release dut.u_cnt_s.cnt_q;
    @(negedge clk);
    n_checks++; if (alarm !== 1'b1) begin n_errors++; $display("FAIL fault_alarm got %b exp 1", alarm); end
    n_checks++; if (remain !== 4'd0) begin n_errors++; $display("FAIL fault_remain got %0d exp 0", remain); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL fault_done got %b exp 0", done); end
    ld = 1'b1; mode = 2'd0;
    tick();
    ld = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      n_checks++; if (done !== 1'b0 || remain !== 4'd0 || busy !== 1'b0) begin
        n_errors++; $display("FAIL fault_locked k=%0d got done=%b remain=%0d busy=%b exp 0/0/0", k, done, remain, busy);
      end
    end
    n_checks++; if (alarm !== 1'b1) begin n_errors++; $display("FAIL fault_sticky got %b exp 1", alarm); end
    rst = 1'b1;
    #1;
    n_checks++; if (alarm !== 1'b0) begin n_errors++; $display("FAIL fault_rst_clear got %b exp 0", alarm); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_illegal_and_async_rst;
    do_rst();
    ld = 1'b1; mode = 2'd3; en = 1'b1;
    tick();
    ld = 1'b0;
    n_checks++; if (alarm !== 1'b1) begin n_errors++; $display("FAIL illegal_alarm got %b exp 1", alarm); end
    n_checks++; if (remain !== 4'd0) begin n_errors++; $display("FAIL illegal_remain got %0d exp 0", remain); end
    do_rst();
    ld = 1'b1; mode = 2'd0; en = 1'b1;
    tick();
    ld = 1'b0;
    repeat (3) tick();
    n_checks++; if (remain !== 4'd8 || busy !== 1'b1) begin n_errors++; $display("FAIL arst_pre got remain=%0d busy=%b exp 8/1", remain, busy); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (remain !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || alarm !== 1'b0) begin
      n_errors++; $display("FAIL arst_mid got remain=%0d busy=%b done=%b alarm=%b exp 0/0/0/0", remain, busy, done, alarm);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (12) tick();
    n_checks++; if (done !== 1'b0 || remain !== 4'd0) begin n_errors++; $display("FAIL arst_after got done=%b remain=%0d exp 0/0", done, remain); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_stall();
    test_back_to_back();
    test_abort();
    test_fault();
    test_illegal_and_async_rst();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
